// File: rtl/camo_key_loader.sv
// Bit-serial loader for the camouflaged-cell select bus: shadow assembly, atomic commit.
// Define CAMO_KEY_CHK_EN to add the 2-bit XOR checksum trailer and a functional err_o.
module camo_key_loader #(
  parameter int NUM_CELLS = 6,
  parameter int SEL_W     = 2,
  localparam int KEY_W    = NUM_CELLS * SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             key_bit_i,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  output logic [KEY_W-1:0] s_o,
  output logic             key_locked_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);
  localparam int CNT_W = $clog2(KEY_W);

`ifdef CAMO_KEY_CHK_EN
  localparam int CC_W = (SEL_W > 1) ? $clog2(SEL_W) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, CHK, COMMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
`endif

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [KEY_W-1:0] shadow_reg;
  logic             accept;
  logic             last_key_bit;
  logic             load_start;

  assign busy_o       = (state_reg != IDLE);
  assign accept       = key_valid_i & key_ready_o;
  assign last_key_bit = (cnt_reg == CNT_W'(KEY_W - 1));
  assign load_start   = start_i & ~abort_i;

`ifdef CAMO_KEY_CHK_EN
  logic [SEL_W-1:0] chk_reg;
  logic [CC_W-1:0]  chk_cnt_reg;
  logic             err_reg;
  logic [SEL_W-1:0] pair [NUM_CELLS];
  logic [SEL_W-1:0] pair_xor;
  logic [SEL_W-1:0] chk_word;
  logic             last_chk_bit;
  logic             chk_ok;

  assign key_ready_o = (state_reg == SHIFT) || (state_reg == CHK);
  assign err_o       = err_reg;

  generate
    for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_pair
      assign pair[gi] = shadow_reg[gi*SEL_W +: SEL_W];
    end
  endgenerate

  always_comb begin
    pair_xor = '0;
    for (int i = 0; i < NUM_CELLS; i++) pair_xor = pair_xor ^ pair[i];
  end

  // The final trailer bit is compared in the cycle it arrives, so merge it in here.
  always_comb begin
    chk_word              = chk_reg;
    chk_word[chk_cnt_reg] = key_bit_i;
  end

  assign last_chk_bit = (chk_cnt_reg == CC_W'(SEL_W - 1));
  assign chk_ok       = (chk_word == pair_xor);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_reg     <= '0;
      chk_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load_start) begin
            chk_reg     <= '0;
            chk_cnt_reg <= '0;
            err_reg     <= 1'b0;
          end
        end
        CHK: begin
          if (!abort_i && accept) begin
            chk_reg[chk_cnt_reg] <= key_bit_i;
            if (last_chk_bit) begin
              if (!chk_ok) err_reg <= 1'b1;
            end else begin
              chk_cnt_reg <= chk_cnt_reg + CC_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign key_ready_o = (state_reg == SHIFT);
  assign err_o       = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (load_start) state_next = SHIFT;
      end
      SHIFT: begin
        if (abort_i) begin
          state_next = IDLE;
        end else if (accept && last_key_bit) begin
`ifdef CAMO_KEY_CHK_EN
          state_next = CHK;
`else
          state_next = COMMIT;
`endif
        end
      end
`ifdef CAMO_KEY_CHK_EN
      CHK: begin
        if (abort_i) begin
          state_next = IDLE;
        end else if (accept && last_chk_bit) begin
          state_next = chk_ok ? COMMIT : IDLE;
        end
      end
`endif
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // s_o is only ever written from the finished shadow, so a partial key is never visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      shadow_reg   <= '0;
      s_o          <= '0;
      key_locked_o <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load_start) begin
            cnt_reg    <= '0;
            shadow_reg <= '0;
          end
        end
        SHIFT: begin
          if (!abort_i && accept) begin
            shadow_reg[cnt_reg] <= key_bit_i;
            if (!last_key_bit) cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        COMMIT: begin
          s_o          <= shadow_reg;
          key_locked_o <= 1'b1;
          done_o       <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_camo_key_loader.sv
// Scoreboarded bench for camo_key_loader: directed loads plus randomized loads with gaps/aborts.
module tb_camo_key_loader;
  localparam int KEY_W = 12;
`ifdef CAMO_KEY_CHK_EN
  localparam int NB  = KEY_W + 2;
  localparam int LAT = 15;
`else
  localparam int NB  = KEY_W;
  localparam int LAT = 13;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0, abort_i = 1'b0, key_bit_i = 1'b0, key_valid_i = 1'b0;
  logic key_ready_o, key_locked_o, busy_o, done_o, err_o;
  logic [KEY_W-1:0] s_o;

  camo_key_loader dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .key_bit_i(key_bit_i), .key_valid_i(key_valid_i), .key_ready_o(key_ready_o),
    .s_o(s_o), .key_locked_o(key_locked_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [KEY_W-1:0] key;
    int               start_cyc;
    bit               chk_lat;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [KEY_W-1:0] model_s = '0;
  logic             model_locked = 1'b0;
  logic             model_err = 1'b0;
  int               cur_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // XOR of the six 2-bit select pairs.
  function automatic logic [1:0] chk_of(input logic [KEY_W-1:0] k);
    logic [1:0] c = 2'b00;
    for (int i = 0; i < KEY_W / 2; i++) c = c ^ 2'((k >> (2 * i)) & 12'h3);
    return c;
  endfunction

  bit prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (done_o) begin
        check("done_pulse_width", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=done_o=1 required=no_commit s_o=%03h", s_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("s_o_commit", {20'd0, s_o}, {20'd0, mon_e.key});
          check("locked_commit", {31'd0, key_locked_o}, 32'd1);
          if (mon_e.chk_lat) check("done_latency", cyc - mon_e.start_cyc, LAT);
          $display("commit key=%03h latency=%0d", s_o, cyc - mon_e.start_cyc);
        end
      end
      prev_done = done_o;
    end
  end

  function automatic int gap_for(input int max_gap);
    if (max_gap < 0) return 1;
    if (max_gap == 0) return 0;
    return $urandom_range(0, max_gap);
  endfunction

  task automatic do_start();
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i   = 1'b0;
    cur_start = cyc;
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      key_valid_i = 1'b0;
    end
    @(negedge clk);
    key_valid_i = 1'b1;
    key_bit_i   = b;
    check("ready_in_load", {31'd0, key_ready_o}, 32'd1);
    check("s_o_stable_in_load", {20'd0, s_o}, {20'd0, model_s});
    @(posedge clk);
    #1;
    key_valid_i = 1'b0;
  endtask

  task automatic run_load(input logic [KEY_W-1:0] key, input logic [1:0] bad_mask,
                          input int abort_at, input int rst_at, input int max_gap);
    logic [NB-1:0] bits;
    logic [1:0]    c;
    c = chk_of(key) ^ bad_mask;
`ifdef CAMO_KEY_CHK_EN
    bits = {c, key};
`else
    bits = key;
`endif
    do_start();
    model_err = 1'b0;
    check("busy_after_start", {31'd0, busy_o}, 32'd1);
    check("err_clear_at_start", {31'd0, err_o}, 32'd0);
    for (int k = 0; k < NB; k++) begin
      if (k == abort_at) begin
        @(negedge clk);
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        check("idle_after_abort", {31'd0, busy_o}, 32'd0);
        check("ready_after_abort", {31'd0, key_ready_o}, 32'd0);
        check("s_o_after_abort", {20'd0, s_o}, {20'd0, model_s});
        check("locked_after_abort", {31'd0, key_locked_o}, {31'd0, model_locked});
        $display("load key=%03h aborted at bit %0d s_o=%03h", key, k, s_o);
        return;
      end
      if (k == rst_at) begin
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_s_o", {20'd0, s_o}, 32'd0);
        check("rst_async_locked", {31'd0, key_locked_o}, 32'd0);
        check("rst_async_busy", {31'd0, busy_o}, 32'd0);
        check("rst_async_ready", {31'd0, key_ready_o}, 32'd0);
        model_s = '0;
        model_locked = 1'b0;
        model_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        $display("load key=%03h reset at bit %0d s_o=%03h", key, k, s_o);
        return;
      end
      if (k == NB - 1 && bad_mask == 2'b00) exp_q.push_back('{key, cur_start, (max_gap == 0)});
      send_bit(bits[k], gap_for(max_gap));
    end
    if (bad_mask != 2'b00) model_err = 1'b1;
    else begin
      model_s = key;
      model_locked = 1'b1;
    end
    repeat (3) @(negedge clk);
    check("done_seen", exp_q.size(), 0);
    check("s_o_after_load", {20'd0, s_o}, {20'd0, model_s});
    check("locked_after_load", {31'd0, key_locked_o}, {31'd0, model_locked});
    check("err_after_load", {31'd0, err_o}, {31'd0, model_err});
    check("idle_after_load", {31'd0, busy_o}, 32'd0);
    $display("load key=%03h chk_mask=%0h gap=%0d s_o=%03h locked=%0b err=%0b",
             key, bad_mask, max_gap, s_o, key_locked_o, err_o);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KEY_W-1:0] rk;
    logic [1:0]       rmask;
    int               rab;
    #1;
    check("rst_s_o", {20'd0, s_o}, 32'd0);
    check("rst_locked", {31'd0, key_locked_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_ready", {31'd0, key_ready_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    start_i = 1'b1;
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    check("start_abort_noop", {31'd0, busy_o}, 32'd0);

    run_load(12'hB4E, 2'b00, -1, -1, 0);
`ifdef CAMO_KEY_CHK_EN
    run_load(12'h123, 2'b11, -1, -1, 0);
`endif
    run_load(12'hFFF, 2'b00, -1, -1, -1);
    run_load(12'h0A5, 2'b00, 5, -1, 0);
    run_load(12'h0A5, 2'b00, -1, -1, 0);
    run_load(12'hB4E, 2'b00, -1, -1, 0);
    run_load(12'h0A5, 2'b00, -1, 7, 0);
    run_load(12'hB4E, 2'b00, -1, -1, 0);

    @(negedge clk);
    key_valid_i = 1'b1;
    key_bit_i   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ready_after_commit", {31'd0, key_ready_o}, 32'd0);
    end
    key_valid_i = 1'b0;
    check("s_o_after_extra_bits", {20'd0, s_o}, {20'd0, model_s});

    for (int n = 0; n < 24; n++) begin
      rk = KEY_W'($urandom);
`ifdef CAMO_KEY_CHK_EN
      rmask = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
`else
      rmask = 2'b00;
`endif
      rab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, NB - 1) : -1;
      run_load(rk, rmask, rab, -1, $urandom_range(0, 2));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
